// File: rtl/riscv_pkg.sv
// Fetch-side RISC-V constants and types shared by the prefetch slice.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    // Sequential word step; wraps from 0xFFFF_FFFC to 0 by plain 32-bit overflow.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/instr_prefetch_buffer_if.sv
// Instruction bus: req/gnt request channel plus in-order rvalid response channel.
// Signal directions are named from the prefetcher's side of the bus.
interface instr_prefetch_buffer_if;

    logic        bus_req_o;
    logic [31:0] bus_addr_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;

    modport master (
        output bus_req_o,
        output bus_addr_o,
        input  bus_gnt_i,
        input  bus_rvalid_i,
        input  bus_rdata_i
    );

    modport slave (
        input  bus_req_o,
        input  bus_addr_o,
        output bus_gnt_i,
        output bus_rvalid_i,
        output bus_rdata_i
    );

endinterface

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with flush; a push is refused while full.
module sync_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [63:0]
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  T                       data_i,
    input  logic                   pop_i,
    output T                       data_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_en, pop_en;

    always_comb begin
        pop_en   = pop_i && (count_q != '0) && !flush_i;
        push_en  = push_i && !flush_i && (count_q != (AW+1)'(DEPTH));
        wr_ptr_d = wr_ptr_q + AW'(push_en);
        rd_ptr_d = rd_ptr_q + AW'(pop_en);
        count_d  = count_q + (AW+1)'(push_en) - (AW+1)'(pop_en);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher feeding IF through a small FIFO, with redirect flush.
// Optional macro PREFETCH_BYPASS_EN forwards a response straight to IF when the FIFO is empty.
module instr_prefetch_buffer
    import riscv_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           redirect_i,
    input  logic [31:0]                    redirect_pc_i,
    output logic                           instr_valid_o,
    output logic [31:0]                    instr_data_o,
    output logic [31:0]                    instr_pc_o,
    input  logic                           instr_ready_i,
    instr_prefetch_buffer_if.master        bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   inflight;
    logic [31:0]   redirect_target;
    logic          gnt_fire, resp_any, resp_keep;
    logic          bypass, push, pop, fifo_empty;
    fetch_entry_t  push_entry, head_entry;

    assign redirect_target = word_align(redirect_pc_i);

    // Buffered plus in-flight words never exceed DEPTH, so every response has a slot.
    assign inflight       = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign bus.bus_req_o  = !rst && !redirect_i && (inflight < (CW+1)'(DEPTH));
    assign bus.bus_addr_o = fetch_pc_q;

    assign gnt_fire   = bus.bus_req_o && bus.bus_gnt_i;
    assign resp_any   = bus.bus_rvalid_i && (outstanding_q != '0);
    assign resp_keep  = resp_any && !redirect_i && (discard_q == '0);
    assign push_entry = '{pc: resp_pc_q, instr: bus.bus_rdata_i};

`ifdef PREFETCH_BYPASS_EN
    assign bypass = resp_keep && fifo_empty;
`else
    assign bypass = 1'b0;
`endif

    assign instr_valid_o = !fifo_empty || bypass;
    assign pop           = !fifo_empty && instr_ready_i && !redirect_i;
    assign push          = resp_keep && !(bypass && instr_ready_i);

    always_comb begin
        instr_data_o = NOP_INSTR;
        instr_pc_o   = '0;
        if (bypass) begin
            instr_data_o = bus.bus_rdata_i;
            instr_pc_o   = resp_pc_q;
        end else if (!fifo_empty) begin
            instr_data_o = head_entry.instr;
            instr_pc_o   = head_entry.pc;
        end
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        if (redirect_i) begin
            // Everything still owed by the bus is stale; a response this cycle is already dropped.
            fetch_pc_d    = redirect_target;
            resp_pc_d     = redirect_target;
            outstanding_d = outstanding_q - CW'(resp_any);
            discard_d     = outstanding_q - CW'(resp_any);
        end else begin
            if (gnt_fire) begin
                fetch_pc_d = next_pc(fetch_pc_q);
            end
            if (resp_keep) begin
                resp_pc_d = next_pc(resp_pc_q);
            end
            outstanding_d = outstanding_q + CW'(gnt_fire) - CW'(resp_any);
            if (resp_any && (discard_q != '0)) begin
                discard_d = discard_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_i),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head_entry),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule
